scratchpad_bank_arbiter: RTL
============================

# scratchpad_bank_arbiter

Round-robin arbiter that shares one OBI scratchpad data-memory bank between `NUM_REQ` requesters, such as the core's per-lane data ports and the controller's external-access path. It sits between the requesters and a bank port in the scratchpad memory hierarchy. It holds the OBI address phase stable on the memory side while a grant is pending. It also routes each read/write response back to the requester that issued it, using an in-order ID FIFO.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; byte-enable width is `DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, 2: depth of the response-routing FIFO (≥1).

Ports:
- `clk_i`  in  1  clock; one clock domain, all state on its rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  NUM_REQ  per-requester OBI req.
- `gnt_o`  out  NUM_REQ  per-requester OBI gnt.
- `addr_i`  in  NUM_REQ×ADDR_WIDTH  request addresses.
- `we_i`  in  NUM_REQ  write enables.
- `be_i`  in  NUM_REQ×DATA_WIDTH/8  byte enables.
- `wdata_i`  in  NUM_REQ×DATA_WIDTH  write data.
- `rvalid_o`  out  NUM_REQ  per-requester response valid.
- `rdata_o`  out  DATA_WIDTH  response data, broadcast to all requesters.
- `mem_req_o`  out  1  memory-side OBI req.
- `mem_gnt_i`  in  1  memory-side gnt.
- `mem_addr_o`  out  ADDR_WIDTH  memory-side address.
- `mem_we_o`  out  1  memory-side write enable.
- `mem_be_o`  out  DATA_WIDTH/8  memory-side byte enables.
- `mem_wdata_o`  out  DATA_WIDTH  memory-side write data.
- `mem_rvalid_i`  in  1  memory-side response valid.
- `mem_rdata_i`  in  DATA_WIDTH  memory-side response data.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- State:
  - `rr_ptr` (log2 NUM_REQ bits).
  - `locked` flag and `lock_idx`.
  - ID FIFO: `MAX_OUTSTANDING` entries of log2 NUM_REQ bits, with a count.
  - `err_o` register.
- `full` = (count == MAX_OUTSTANDING).
- Selection:
  - When `locked`=1: `sel` = `lock_idx`.
  - Otherwise: `sel` = first `i` with `req_i[i]`=1, searching `rr_ptr`, `rr_ptr`+1, … modulo NUM_REQ.
- `mem_req_o` = !full & (locked | (|req_i)).
- `mem_addr_o`/`mem_we_o`/`mem_be_o`/`mem_wdata_o` = fields of `sel`. When `mem_req_o`=0 they are don't-care but driven from `sel`, never X.
- `gnt_o[sel]` = `mem_req_o` & `mem_gnt_i`. All other `gnt_o` bits are 0.
- Handshake (`mem_req_o` & `mem_gnt_i`):
  - push `sel` into the FIFO;
  - `rr_ptr` <= (`sel`+1) mod NUM_REQ;
  - `locked` <= 0.
- Lock: if `mem_req_o`=1 and `mem_gnt_i`=0, then `locked` <= 1 and `lock_idx` <= `sel`. A newly arriving higher-priority request cannot change the memory-side address phase before the grant.
- Response:
  - When `mem_rvalid_i`=1 and the FIFO is non-empty: pop the head, assert `rvalid_o[head]`=1 (all others 0), `rdata_o` = `mem_rdata_i`.
  - `rdata_o` = `mem_rdata_i` at all times.
- Simultaneous push and pop: the count is unchanged and FIFO order is preserved.
- Full FIFO: `mem_req_o`=0 even if a pop happens in the same cycle, so there is no combinational path from `mem_rvalid_i` to `mem_req_o`. A lock already held stays held while full.
- `mem_rvalid_i`=1 with an empty FIFO: no `rvalid_o` asserted, and `err_o` <= 1. `err_o` stays set until reset.
- A requester dropping `req_i` while locked is an OBI violation by that requester. The arbiter keeps presenting `lock_idx` until the grant.

## Timing
- Reset (async assert, sync deassert is external):
  - `rr_ptr`=0, `locked`=0, FIFO empty, `err_o`=0.
  - All outputs therefore read 0: `gnt_o`, `rvalid_o`, `mem_req_o`.
- Request-to-grant is combinational: `gnt_o` rises in the same cycle as `mem_gnt_i` when `sel` is that requester.
- Response path is combinational: `rvalid_o` rises in the same cycle as `mem_rvalid_i`.
- The earliest response is the cycle after the grant. A response in the grant cycle is not supported.
- Throughput: one handshake per cycle while the FIFO is not full and `mem_gnt_i`=1.
- With a 1-cycle memory, `MAX_OUTSTANDING`=2 sustains back-to-back grants.
- Reset mid-transaction discards the FIFO contents. Responses arriving after reset set `err_o`.

## Test plan
- **Reset:** assert `rst_ni`=0 for 3 cycles with all `req_i`=1 → `mem_req_o`=0, `gnt_o`=0, `rvalid_o`=0, `err_o`=0 throughout.
- **Round-robin:**
  - Stimulus: `req_i`=4'b1111 held, `mem_gnt_i`=1, 1-cycle read memory.
  - Required: grants go to requesters 0,1,2,3,0 on consecutive cycles; each `rvalid_o[i]` follows its grant by one cycle with matching data.
- **Lock:**
  - Stimulus: `req_i`=4'b0100, `mem_gnt_i`=0 for 3 cycles; `req_i[0]` rises in cycle 1; `mem_gnt_i`=1 in cycle 3.
  - Required: `mem_addr_o` stays requester 2's address through cycles 0–3; `gnt_o`=4'b0100 in cycle 3; requester 0 is granted in cycle 4.
- **Full FIFO:**
  - Stimulus: `MAX_OUTSTANDING`=2, memory withholds `mem_rvalid_i`, requester 1 requests continuously.
  - Required: two grants, then `mem_req_o`=0; first `mem_rvalid_i` → `rvalid_o[1]`=1 and `mem_req_o`=1 on the next cycle.
- **Out-of-order issuers:**
  - Stimulus: grant requester 3 then requester 1; responses come with data A then B.
  - Required: `rvalid_o[3]` with A, then `rvalid_o[1]` with B.
- **Spurious response:** `mem_rvalid_i`=1 with an empty FIFO → `rvalid_o`=0 and `err_o`=1, which stays set until `rst_ni`=0.

Source files
------------

// File: rtl/scratchpad_bank_arbiter.sv
// Round-robin arbiter sharing one OBI scratchpad bank between NUM_REQ requesters, with in-order response routing.
// Latency: grant and response routing are combinational (same cycle as mem_gnt_i / mem_rvalid_i); no added pipeline stage.
// Backpressure: a pending grant locks the address phase; mem_req_o drops while MAX_OUTSTANDING responses are in flight.
module scratchpad_bank_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_REQ-1:0]                    req_i,
    output logic [NUM_REQ-1:0]                    gnt_o,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ-1:0]                    we_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  be_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]                    rvalid_o,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic                                  mem_req_o,
    input  logic                                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
    output logic                                  mem_we_o,
    output logic [DATA_WIDTH/8-1:0]               mem_be_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
    input  logic                                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
    output logic                                  err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic             locked;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] rr_sel;
    logic [IDX_W-1:0] sel;
    logic             found;
    int               cand;

    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             hs;
    logic             pop;
    logic [IDX_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count == '0);
    assign head  = fifo_q[rd_ptr];

    // Rotating-priority search: first requester at or after rr_ptr.
    always_comb begin
        rr_sel = rr_ptr;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_i[IDX_W'(cand)]) begin
                rr_sel = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end

    // A stalled address phase stays pinned to the locked requester.
    assign sel = locked ? lock_idx : rr_sel;

    // Held low during reset so nothing is issued before the state is valid.
    assign mem_req_o   = rst_ni & ~full & (locked | (|req_i));
    assign mem_addr_o  = addr_i[sel];
    assign mem_we_o    = we_i[sel];
    assign mem_be_o    = be_i[sel];
    assign mem_wdata_o = wdata_i[sel];
    assign hs          = mem_req_o & mem_gnt_i;
    assign pop         = mem_rvalid_i & ~empty;
    assign rdata_o     = mem_rdata_i;

    // Grant goes only to the selected requester on a memory handshake.
    always_comb begin
        gnt_o = '0;
        if (hs) gnt_o[sel] = 1'b1;
    end

    // Response valid goes to the requester at the head of the ID FIFO.
    always_comb begin
        rvalid_o = '0;
        if (pop) rvalid_o[head] = 1'b1;
    end

    // Arbitration state: advance priority past the winner, lock on a stalled request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (hs) begin
            rr_ptr   <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            locked   <= 1'b0;
        end else if (mem_req_o) begin
            locked   <= 1'b1;
            lock_idx <= sel;
        end
    end

    // ID FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (hs)  wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (hs && !pop)      count <= count + 1'b1;
            else if (!hs && pop) count <= count - 1'b1;
        end
    end

    // ID FIFO storage; entries are only read while the count covers them.
    always_ff @(posedge clk_i) begin
        if (hs) fifo_q[wr_ptr] <= sel;
    end

    // Sticky error on a response that no outstanding request accounts for.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                err_o <= 1'b0;
        else if (mem_rvalid_i && empty) err_o <= 1'b1;
    end

endmodule
